// File: rtl/dff_skid_if.sv
// Valid/ready handshake bundle for the dff_skid pipeline slice.
// The slave modport is the slice's view; the master modport is the
// environment (producer and consumer) driving the slice.
interface dff_skid_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic [1:0]            level;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, level
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, level
    );
endinterface

// File: rtl/dff_skid.sv
// Two-entry registered pipeline slice. The consumer's stall is absorbed
// by a skid register, so out_ready never reaches in_ready through logic.
// Every output comes from the state register or the main data register.
//
// state | meaning
// ------+-----------------------------------------------------------
// EMPTY | no word held; out_valid=0, in_ready=1, level=0
// ONE   | head word in main; out_valid=1, in_ready=1, level=1
// TWO   | head in main, next word in skid; in_ready=0, level=2
// (3)   | illegal encoding; behaves as EMPTY and returns to EMPTY
module dff_skid #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic       clock,
    input  logic       reset,
    dff_skid_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;

    logic in_fire;
    logic out_fire;
    logic load_main;
    logic main_from_skid;
    logic load_skid;

    logic ready_dec;
    logic valid_dec;

    // Output decode from the state register only.
    always_comb begin
        ready_dec = 1'b1;
        valid_dec = 1'b0;
        bus.level = 2'd0;
        case (state)
            ONE: begin
                valid_dec = 1'b1;
                bus.level = 2'd1;
            end
            TWO: begin
                ready_dec = 1'b0;
                valid_dec = 1'b1;
                bus.level = 2'd2;
            end
            default: ;
        endcase
    end

    assign bus.in_ready  = ready_dec;
    assign bus.out_valid = valid_dec;
    assign bus.out_data  = main_q;

    assign in_fire  = bus.in_valid & ready_dec;
    assign out_fire = valid_dec & bus.out_ready;

    // Next-state and register-load decisions.
    always_comb begin
        state_next     = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_main  = 1'b1;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    load_skid  = 1'b1;
                    state_next = TWO;
                end else if (out_fire) begin
                    // main keeps its stale word; out_valid hides it
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_next     = ONE;
                end
            end
            default: begin
                // a word accepted here is dropped, but illegal state
                // is only reachable through an upset, not normal flow
                state_next = EMPTY;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Main (head) register, loaded from the producer or from skid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_q <= RESET_VALUE;
        end else if (load_main) begin
            main_q <= main_from_skid ? skid_q : bus.in_data;
        end
    end

    // Skid register, holds the word absorbed during a stall.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            skid_q <= RESET_VALUE;
        end else if (load_skid) begin
            skid_q <= bus.in_data;
        end
    end

endmodule
